// File: rtl/pq_gen.sv
// Sorted-register priority queue: slot 0 holds the best key. Supports push, pop,
// replace (push+pop) and drop-by-id. Ids come from a free bitmap.
module pq_gen #(
    parameter int DEPTH     = 8,
    parameter int DW        = 8,
    parameter int MAX_FIRST = 0,
    localparam int IDW      = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  logic [DW-1:0]  push_data_i,
    output logic           push_rdy_o,
    output logic [IDW-1:0] push_id_o,
    input  logic           pop_i,
    output logic           pop_rdy_o,
    output logic           pop_vld_o,
    output logic [DW-1:0]  pop_data_o,
    output logic [IDW-1:0] pop_id_o,
    input  logic           drop_i,
    input  logic [IDW-1:0] drop_id_i,
    output logic           drop_rdy_o,
    output logic           drop_hit_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [CW-1:0]  cnt_o,
    output logic           peek_vld_o,
    output logic [DW-1:0]  peek_data_o,
    output logic [IDW-1:0] peek_id_o,
    output logic           overflow_o,
    output logic [DW-1:0]  overflow_data_o,
    output logic [IDW-1:0] overflow_id_o
);

    logic [DW-1:0]    key_q [DEPTH];
    logic [DW-1:0]    key_d [DEPTH];
    logic [IDW-1:0]   id_q  [DEPTH];
    logic [IDW-1:0]   id_d  [DEPTH];
    logic [DW-1:0]    key_m [DEPTH];
    logic [IDW-1:0]   id_m  [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d, cnt_m, cnt_eff, pos;
    logic [DEPTH-1:0] free_q, free_d;
    logic             pop_vld_q, pop_vld_d;
    logic [DW-1:0]    pop_data_q, pop_data_d;
    logic [IDW-1:0]   pop_id_q, pop_id_d;
    logic             drop_hit_q, drop_hit_d;
    logic             ovf_q, ovf_d;
    logic [DW-1:0]    ovf_data_q, ovf_data_d;
    logic [IDW-1:0]   ovf_id_q, ovf_id_d;

    logic             push_acc, pop_acc, drop_acc, drop_hit, rm_en, ins, evict, reject;
    logic [IDW-1:0]   free_id, drop_idx, rm_idx;

    function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (MAX_FIRST != 0) return a > b;
        else return a < b;
    endfunction

    assign full_o          = (cnt_q == CW'(DEPTH));
    assign empty_o         = (cnt_q == '0);
    assign cnt_o           = cnt_q;
    assign peek_vld_o      = ~empty_o;
    assign peek_data_o     = key_q[0];
    assign peek_id_o       = id_q[0];
    assign push_rdy_o      = ~rst_i;
    assign pop_rdy_o       = ~rst_i & ~empty_o;
    assign drop_rdy_o      = ~rst_i & ~push_i & ~pop_i & ~empty_o;
    assign pop_vld_o       = pop_vld_q;
    assign pop_data_o      = pop_data_q;
    assign pop_id_o        = pop_id_q;
    assign drop_hit_o      = drop_hit_q;
    assign overflow_o      = ovf_q;
    assign overflow_data_o = ovf_data_q;
    assign overflow_id_o   = ovf_id_q;

    always_comb begin
        push_acc = push_i & push_rdy_o;
        pop_acc  = pop_i & pop_rdy_o;
        drop_acc = drop_i & drop_rdy_o;

        free_id = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (free_q[i]) free_id = IDW'(i);
        // A full-queue replace reuses the head id that is freed in the same cycle.
        if (full_o) push_id_o = pop_acc ? id_q[0] : id_q[DEPTH-1];
        else        push_id_o = free_id;

        drop_hit = drop_acc & ~free_q[drop_id_i];
        drop_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < cnt_q && id_q[i] == drop_id_i) drop_idx = IDW'(i);

        rm_en  = pop_acc | drop_hit;
        rm_idx = pop_acc ? '0 : drop_idx;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (rm_en && IDW'(i) >= rm_idx) begin
                key_m[i] = key_q[i+1];
                id_m[i]  = id_q[i+1];
            end else begin
                key_m[i] = key_q[i];
                id_m[i]  = id_q[i];
            end
        end
        key_m[DEPTH-1] = rm_en ? '0 : key_q[DEPTH-1];
        id_m[DEPTH-1]  = rm_en ? '0 : id_q[DEPTH-1];
        cnt_m = rm_en ? cnt_q - CW'(1) : cnt_q;

        ins     = push_acc;
        evict   = 1'b0;
        reject  = 1'b0;
        cnt_eff = cnt_m;
        if (push_acc && cnt_m == CW'(DEPTH)) begin
            if (better(push_data_i, key_m[DEPTH-1])) begin
                evict   = 1'b1;
                cnt_eff = CW'(DEPTH - 1);
            end else begin
                reject = 1'b1;
                ins    = 1'b0;
            end
        end

        // Position after every entry the new key does not beat keeps FIFO order among equals.
        pos = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < cnt_eff && !better(push_data_i, key_m[i])) pos = pos + CW'(1);

        key_d = key_m;
        id_d  = id_m;
        if (ins) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if (CW'(i) > pos) begin
                    key_d[i] = key_m[i-1];
                    id_d[i]  = id_m[i-1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == pos) begin
                    key_d[i] = push_data_i;
                    id_d[i]  = push_id_o;
                end
            end
        end
        cnt_d = ins ? cnt_eff + CW'(1) : cnt_eff;

        free_d = free_q;
        if (pop_acc)  free_d[id_q[0]]    = 1'b1;
        if (drop_hit) free_d[drop_id_i]  = 1'b1;
        if (ins)      free_d[push_id_o]  = 1'b0;

        pop_vld_d  = pop_acc;
        pop_data_d = pop_acc ? key_q[0] : pop_data_q;
        pop_id_d   = pop_acc ? id_q[0]  : pop_id_q;
        drop_hit_d = drop_hit;
        ovf_d      = evict | reject;
        ovf_data_d = evict ? key_m[DEPTH-1] : (reject ? push_data_i : ovf_data_q);
        ovf_id_d   = (evict | reject) ? push_id_o : ovf_id_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                id_q[i]  <= '0;
            end
            cnt_q      <= '0;
            free_q     <= '1;
            pop_vld_q  <= 1'b0;
            pop_data_q <= '0;
            pop_id_q   <= '0;
            drop_hit_q <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_data_q <= '0;
            ovf_id_q   <= '0;
        end else begin
            key_q      <= key_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            free_q     <= free_d;
            pop_vld_q  <= pop_vld_d;
            pop_data_q <= pop_data_d;
            pop_id_q   <= pop_id_d;
            drop_hit_q <= drop_hit_d;
            ovf_q      <= ovf_d;
            ovf_data_q <= ovf_data_d;
            ovf_id_q   <= ovf_id_d;
        end
    end

endmodule

// File: tb/tb_pq_gen.sv
// Bench for pq_gen (DEPTH=4, DW=8): min-first instance plus a max-first twin on shared inputs.
module tb_pq_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, pop = 1'b0, drop = 1'b0;
    logic [7:0] push_data = '0;
    logic [1:0] drop_id = '0;

    logic       push_rdy, pop_rdy, pop_vld, drop_rdy, drop_hit, full, empty, peek_vld, ovf;
    logic [1:0] push_id, pop_id, peek_id, ovf_id;
    logic [7:0] pop_data, peek_data, ovf_data;
    logic [2:0] cnt;

    logic       push_rdy1, pop_rdy1, pop_vld1, drop_rdy1, drop_hit1, full1, empty1, peek_vld1, ovf1;
    logic [1:0] push_id1, pop_id1, peek_id1, ovf_id1;
    logic [7:0] pop_data1, peek_data1, ovf_data1;
    logic [2:0] cnt1;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];
    logic [9:0] exp_e;

    always #5 clk = ~clk;

    pq_gen #(.DEPTH(4), .DW(8), .MAX_FIRST(0)) u0 (
        .clk_i(clk), .rst_i(rst), .push_i(push), .push_data_i(push_data), .push_rdy_o(push_rdy),
        .push_id_o(push_id), .pop_i(pop), .pop_rdy_o(pop_rdy), .pop_vld_o(pop_vld),
        .pop_data_o(pop_data), .pop_id_o(pop_id), .drop_i(drop), .drop_id_i(drop_id),
        .drop_rdy_o(drop_rdy), .drop_hit_o(drop_hit), .full_o(full), .empty_o(empty), .cnt_o(cnt),
        .peek_vld_o(peek_vld), .peek_data_o(peek_data), .peek_id_o(peek_id),
        .overflow_o(ovf), .overflow_data_o(ovf_data), .overflow_id_o(ovf_id));

    pq_gen #(.DEPTH(4), .DW(8), .MAX_FIRST(1)) u1 (
        .clk_i(clk), .rst_i(rst), .push_i(push), .push_data_i(push_data), .push_rdy_o(push_rdy1),
        .push_id_o(push_id1), .pop_i(pop), .pop_rdy_o(pop_rdy1), .pop_vld_o(pop_vld1),
        .pop_data_o(pop_data1), .pop_id_o(pop_id1), .drop_i(drop), .drop_id_i(drop_id),
        .drop_rdy_o(drop_rdy1), .drop_hit_o(drop_hit1), .full_o(full1), .empty_o(empty1), .cnt_o(cnt1),
        .peek_vld_o(peek_vld1), .peek_data_o(peek_data1), .peek_id_o(peek_id1),
        .overflow_o(ovf1), .overflow_data_o(ovf_data1), .overflow_id_o(ovf_id1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; drop = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] d);
        push = 1'b1; push_data = d;
        step();
        push = 1'b0;
    endtask

    // Expected head is queued as the pop is driven; compared when pop_vld_o appears.
    task automatic do_pop(input logic [7:0] d, input logic [1:0] id);
        sb.push_back({d, id});
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++;
        if (pop_vld !== 1'b1) begin
            errors++; $display("FAIL pop_vld: got %0b expected 1", pop_vld);
            void'(sb.pop_front());
        end else begin
            exp_e = sb.pop_front();
            checks++;
            if ({pop_data, pop_id} !== exp_e) begin
                errors++;
                $display("FAIL pop_entry: got data %0h id %0d expected data %0h id %0d",
                         pop_data, pop_id, exp_e[9:2], exp_e[1:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({push_rdy, pop_rdy, drop_rdy} !== 3'b000) begin
            errors++; $display("FAIL rdy_in_reset: got %b expected 000", {push_rdy, pop_rdy, drop_rdy});
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({cnt, empty, full, peek_vld, pop_vld, ovf, drop_hit} !== {3'd0, 6'b100000}) begin
            errors++; $display("FAIL reset_state: got cnt %0d flags %b expected cnt 0 flags 100000",
                               cnt, {empty, full, peek_vld, pop_vld, ovf, drop_hit});
        end
        checks++;
        if ({pop_data, pop_id, ovf_data, ovf_id, push_id} !== 22'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {pop_data, pop_id, ovf_data, ovf_id, push_id});
        end
    endtask

    task automatic test_order();
        do_reset();
        do_push(8'hF0); do_push(8'h15); do_push(8'h87);
        do_pop(8'h15, 2'd1); do_pop(8'h87, 2'd2); do_pop(8'hF0, 2'd0);
        checks++;
        if ({empty, cnt} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL order_drained: got empty %0b cnt %0d expected 1 0", empty, cnt);
        end
    endtask

    task automatic test_fifo_equal();
        do_reset();
        push = 1'b1; push_data = 8'h20;
        #1;
        checks++;
        if (push_id !== 2'd0) begin errors++; $display("FAIL eq_id0: got %0d expected 0", push_id); end
        step();
        checks++;
        if (push_id !== 2'd1) begin errors++; $display("FAIL eq_id1: got %0d expected 1", push_id); end
        step();
        push = 1'b0;
        do_pop(8'h20, 2'd0); do_pop(8'h20, 2'd1);
    endtask

    task automatic test_overflow();
        do_reset();
        do_push(8'h10); do_push(8'h20); do_push(8'h30); do_push(8'h40);
        checks++;
        if ({full, cnt} !== {1'b1, 3'd4}) begin
            errors++; $display("FAIL ovf_full: got full %0b cnt %0d expected 1 4", full, cnt);
        end
        do_push(8'h05);
        checks++;
        if ({ovf, ovf_data, ovf_id} !== {1'b1, 8'h40, 2'd3}) begin
            errors++; $display("FAIL ovf_evict: got %0b %0h %0d expected 1 40 3", ovf, ovf_data, ovf_id);
        end
        checks++;
        if ({peek_data, peek_id, cnt} !== {8'h05, 2'd3, 3'd4}) begin
            errors++; $display("FAIL ovf_peek: got %0h %0d cnt %0d expected 05 3 4", peek_data, peek_id, cnt);
        end
        step();
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse: got %0b expected 0", ovf); end
        do_push(8'h50);
        checks++;
        if ({ovf, ovf_data, ovf_id} !== {1'b1, 8'h50, 2'd2}) begin
            errors++; $display("FAIL ovf_reject: got %0b %0h %0d expected 1 50 2", ovf, ovf_data, ovf_id);
        end
        do_pop(8'h05, 2'd3); do_pop(8'h10, 2'd0); do_pop(8'h20, 2'd1); do_pop(8'h30, 2'd2);
    endtask

    task automatic test_replace();
        do_reset();
        do_push(8'h10); do_push(8'h20);
        push = 1'b1; push_data = 8'h15;
        #1;
        checks++;
        if (push_id !== 2'd2) begin errors++; $display("FAIL repl_id: got %0d expected 2", push_id); end
        do_pop(8'h10, 2'd0);
        push = 1'b0;
        checks++;
        if ({cnt, peek_data, peek_id, ovf} !== {3'd2, 8'h15, 2'd2, 1'b0}) begin
            errors++; $display("FAIL repl_state: got cnt %0d peek %0h id %0d ovf %0b expected 2 15 2 0",
                               cnt, peek_data, peek_id, ovf);
        end
        checks++;
        if ({pop_vld1, pop_data1, peek_data1, cnt1} !== {1'b1, 8'h20, 8'h15, 3'd2}) begin
            errors++; $display("FAIL repl_max: got vld %0b pop %0h peek %0h cnt %0d expected 1 20 15 2",
                               pop_vld1, pop_data1, peek_data1, cnt1);
        end
        do_pop(8'h15, 2'd2); do_pop(8'h20, 2'd1);
    endtask

    task automatic test_drop();
        do_reset();
        do_push(8'h01); do_push(8'hEB); do_push(8'hAF);
        drop = 1'b1; drop_id = 2'd2;
        #1;
        checks++;
        if (drop_rdy !== 1'b1) begin errors++; $display("FAIL drop_rdy: got %0b expected 1", drop_rdy); end
        step();
        drop = 1'b0;
        checks++;
        if ({drop_hit, cnt} !== {1'b1, 3'd2}) begin
            errors++; $display("FAIL drop_hit: got %0b cnt %0d expected 1 2", drop_hit, cnt);
        end
        drop = 1'b1; drop_id = 2'd3;
        step();
        drop = 1'b0;
        checks++;
        if ({drop_hit, cnt} !== {1'b0, 3'd2}) begin
            errors++; $display("FAIL drop_miss: got %0b cnt %0d expected 0 2", drop_hit, cnt);
        end
        drop = 1'b1; drop_id = 2'd1; pop = 1'b1;
        #1;
        checks++;
        if (drop_rdy !== 1'b0) begin errors++; $display("FAIL drop_pop_rdy: got %0b expected 0", drop_rdy); end
        pop = 1'b0;
        do_pop(8'h01, 2'd0);
        drop = 1'b0;
        checks++;
        if ({drop_hit, cnt} !== {1'b0, 3'd1}) begin
            errors++; $display("FAIL drop_pop_only: got %0b cnt %0d expected 0 1", drop_hit, cnt);
        end
        do_pop(8'hEB, 2'd1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_push(8'h33); do_push(8'h22); do_push(8'h11);
        checks++;
        if (cnt !== 3'd3) begin errors++; $display("FAIL mid_cnt: got %0d expected 3", cnt); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        rst = 1'b1; push = 1'b1; push_data = 8'h77;
        step();
        rst = 1'b0; push = 1'b0;
        checks++;
        if ({cnt, empty, pop_vld, ovf, drop_hit} !== {3'd0, 4'b1000}) begin
            errors++; $display("FAIL mid_reset: got cnt %0d flags %b expected 0 1000",
                               cnt, {empty, pop_vld, ovf, drop_hit});
        end
        push = 1'b1; push_data = 8'h44;
        #1;
        checks++;
        if (push_id !== 2'd0) begin errors++; $display("FAIL mid_first_id: got %0d expected 0", push_id); end
        step();
        push = 1'b0;
        do_pop(8'h44, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_order();
        test_fifo_equal();
        test_overflow();
        test_replace();
        test_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pq_gen.md
PQ_GEN -- requirements
Module: pq_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, >=2).
REQ-002 SHALL have parameter DW, default 8, key width.
REQ-003 SHALL have parameter MAX_FIRST, default 0, ordering mode (0: smallest key first; 1: largest key first).
REQ-004 SHALL derive IDW = $clog2(DEPTH) and CW = $clog2(DEPTH+1).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 push_i  in  1; push_data_i  in  DW; push_rdy_o  out  1; push_id_o  out  IDW (id assigned if this cycle's push is accepted).
REQ-009 pop_i  in  1; pop_rdy_o  out  1; pop_vld_o  out  1; pop_data_o  out  DW; pop_id_o  out  IDW.
REQ-010 drop_i  in  1; drop_id_i  in  IDW; drop_rdy_o  out  1; drop_hit_o  out  1.
REQ-011 full_o, empty_o  out  1; cnt_o  out  CW; peek_vld_o  out  1; peek_data_o  out  DW; peek_id_o  out  IDW.
REQ-012 overflow_o  out  1; overflow_data_o  out  DW; overflow_id_o  out  IDW.

Function
REQ-013 SHALL store entries {key,id} in a sorted register array; slot 0 is head (best key); "better" means strictly smaller (MAX_FIRST=0) or strictly larger (MAX_FIRST=1).
REQ-014 SHALL insert a new key after all stored entries with an equal key (FIFO among equals).
REQ-015 Handshakes: op accepted when x_i & x_rdy_o at posedge; all rdy outputs 0 while rst_i=1.
REQ-016 push_rdy_o = 1 outside reset; pop_rdy_o = ~empty_o; drop_rdy_o = ~push_i & ~pop_i & ~empty_o (drop lowest priority).
REQ-017 push_id_o: lowest-index free id when not full; tail-entry id when full.
REQ-018 Id allocation SHALL use a DEPTH-bit free bitmap; id set busy on insert, freed on pop, drop or eviction; stored ids always unique.
REQ-019 Accepted pop: head removed, entries shift toward head, cnt_o-1; next cycle pop_vld_o=1 one cycle with pop_data_o/pop_id_o = removed head; pop_data_o/pop_id_o hold until next pop.
REQ-020 Accepted push, not full: entry inserted at sorted position, cnt_o+1.
REQ-021 Push when full and new key better than tail: tail evicted, new entry inserted with tail's id; next cycle overflow_o=1 one cycle, overflow_data_o/id_o = evicted entry.
REQ-022 Push when full and new key not better: queue unchanged; next cycle overflow_o=1, overflow_data_o = push_data_i, overflow_id_o = push_id_o as offered.
REQ-023 Push and pop accepted same cycle (replace): head removed and new entry inserted in one cycle, cnt_o unchanged, never overflow, pop_vld_o as REQ-019; new id = freed head id if queue was full, else per REQ-017.
REQ-024 Push+pop with empty queue: pop not accepted, push alone.
REQ-025 Accepted drop: if drop_id_i busy, that entry removed, later entries shift up, id freed, cnt_o-1, drop_hit_o=1 next cycle for one cycle; if id free, no state change, drop_hit_o=0.
REQ-026 full_o = (cnt_o==DEPTH); empty_o = (cnt_o==0); peek_vld_o = ~empty_o; peek_data_o/peek_id_o = slot 0, combinational from registers.
REQ-027 All state updates single-cycle; no multi-cycle busy state.

Reset
REQ-028 rst_i=1 at posedge SHALL clear: cnt_o=0, empty_o=1, full_o=0, free bitmap all free, pop_vld_o=0, drop_hit_o=0, overflow_o=0, pop_data_o/pop_id_o/overflow_data_o/overflow_id_o/array = 0; ops that cycle ignored.
REQ-029 Reset mid-operation SHALL discard contents; first push after reset gets id 0.

Verification (DEPTH=4, DW=8, MAX_FIRST=0 unless stated)
REQ-030 push F0,15,87, pop x3 -> pop_data_o 15,87,F0; empty_o=1, cnt_o=0.
REQ-031 push 20,20 -> ids 0,1; pop x2 -> pop_id_o 0 then 1.
REQ-032 push 10,20,30,40 then 05 -> overflow_o pulse data 40 id 3, peek 05 id 3, cnt_o 4; push 50 -> overflow data 50, contents unchanged.
REQ-033 queue {10,20}, push 15 with pop same cycle -> pop_data_o 10, cnt_o 2, peek_data_o 15; MAX_FIRST=1 same stimulus -> pop_data_o 20, peek 15.
REQ-034 push 01,EB,AF (ids 0,1,2), drop id 2 -> drop_hit_o=1, queue {01,EB}; drop id 3 -> drop_hit_o=0; drop_i with pop_i -> drop_rdy_o=0, pop only.
REQ-035 cnt_o=3, assert rst_i one cycle with push_i=1 -> cnt_o 0, empty_o 1, all pulses 0; next push -> push_id_o 0.
